// File: rtl/dpram_wr_arbiter_pkg.sv
// Shared types and helpers for the DPRAM write-port arbiter.
package dpram_wr_arbiter_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    typedef enum logic {
        StIdle  = ST_IDLE,
        StBurst = ST_BURST
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(n)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/dpram_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping mod NREQ.
module rr_pick
    import dpram_wr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    int unsigned j;
    logic [IW-1:0] jj;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        jj  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j  = (32'(ptr) + k) % NREQ;
            jj = IW'(j);
            if (!any && req[jj]) begin
                any = 1'b1;
                idx = jj;
            end
        end
    end

endmodule

// File: rtl/dpram_wr_arbiter.sv
// Round-robin arbiter sharing one DPRAM write port among NREQ valid/ready requesters,
// holding each grant for a burst ending on req_last or after MAX_BURST beats.
module dpram_wr_arbiter
    import dpram_wr_arbiter_pkg::*;
#(
    parameter  int unsigned WIDTH     = 16,
    parameter  int unsigned DEPTH     = 16,
    parameter  int unsigned ADDR      = 4,
    parameter  int unsigned NREQ      = 4,
    parameter  int unsigned MAX_BURST = 8,
    localparam int unsigned GW        = clog2(NREQ)
) (
    input  logic                  wrclk,
    input  logic                  rd_rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*ADDR-1:0]  req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  wr_en,
    output logic [ADDR-1:0]       wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic [GW-1:0]         grant_id,
    output logic                  busy
);

    localparam int unsigned BW = (clog2(MAX_BURST) > 0) ? clog2(MAX_BURST) : 1;

    if (DEPTH != (1 << ADDR)) begin : g_bad_depth
        $error("DEPTH must equal 2**ADDR");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("NREQ must be in 2..8");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("MAX_BURST must be at least 1");
    end

    state_e            state_q;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     rr_ptr_q;
    logic [BW-1:0]     beat_cnt_q;
    logic              wr_en_q;
    logic [ADDR-1:0]   wr_addr_q;
    logic [WIDTH-1:0]  wr_data_q;

    logic              pick_any;
    logic [GW-1:0]     pick_idx;
    logic              accept;
    logic              burst_end;
    logic [ADDR-1:0]   sel_addr;
    logic [WIDTH-1:0]  sel_data;
    logic [GW-1:0]     next_ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (GW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign sel_addr  = req_addr[32'(grant_q) * ADDR +: ADDR];
    assign sel_data  = req_data[32'(grant_q) * WIDTH +: WIDTH];
    assign accept    = (state_q == StBurst) && req_valid[grant_q];
    // Forced end on the MAX_BURST-th beat even without req_last.
    assign burst_end = accept && (req_last[grant_q] || beat_cnt_q == BW'(MAX_BURST - 1));
    assign next_ptr  = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state_q == StBurst) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_ff @(posedge wrclk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        grant_q    <= pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= StBurst;
                    end
                end
                StBurst: begin
                    if (accept) begin
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= sel_addr;
                        wr_data_q  <= sel_data;
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                    if (burst_end) begin
                        state_q  <= StIdle;
                        rr_ptr_q <= next_ptr;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_q;
    assign busy     = (state_q == StBurst);

endmodule

// File: tb/tb_dpram_wr_arbiter.sv
// Directed plus randomized bench for dpram_wr_arbiter with a queue-based reference model.
module tb_dpram_wr_arbiter;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned ADDR      = 4;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned MAX_BURST = 8;
    localparam int unsigned GW        = 2;

    typedef struct packed {
        logic [ADDR-1:0]  addr;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic                  wrclk = 1'b0;
    logic                  rd_rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_last = '0;
    logic [NREQ*ADDR-1:0]  req_addr = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  wr_en;
    logic [ADDR-1:0]       wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic [GW-1:0]         grant_id;
    logic                  busy;

    dpram_wr_arbiter #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR      (ADDR),
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wrclk     (wrclk),
        .rd_rst_n  (rd_rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 wrclk = ~wrclk;

    // Requester-side beat queues and reference model state
    beat_t q[NREQ][$];
    bit    stall[NREQ];
    bit    junk_valid;
    int    acc_cnt[NREQ];
    int    n_total, n_pass;

    bit               m_busy;
    int               m_grant, m_cnt, m_ptr;
    bit               m_wr_en;
    logic [ADDR-1:0]  m_addr;
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] mem_model[DEPTH];
    logic [WIDTH-1:0] mem_dut[DEPTH];
    int               grants[$];
    bit               prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int i, input int a, input int d, input bit l);
        beat_t b;
        b.addr = ADDR'(a);
        b.data = WIDTH'(d);
        b.last = l;
        q[i].push_back(b);
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_grant = 0;
        m_cnt   = 0;
        m_ptr   = 0;
        m_wr_en = 0;
        m_addr  = '0;
        m_data  = '0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() > 0 && !stall[i]) begin
                req_valid[i]              = 1'b1;
                req_last[i]               = q[i][0].last;
                req_addr[i*ADDR +: ADDR]  = q[i][0].addr;
                req_data[i*WIDTH +: WIDTH] = q[i][0].data;
            end else begin
                req_valid[i]              = junk_valid ? 1'($urandom) : 1'b0;
                req_last[i]               = 1'($urandom);
                req_addr[i*ADDR +: ADDR]  = ADDR'($urandom);
                req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
        end
    endtask

    // One clock edge of the arbiter as described by its rules
    task automatic model_step();
        if (!rd_rst_n) begin
            model_reset();
            return;
        end
        if (m_wr_en) mem_model[m_addr] = m_data;
        m_wr_en = 0;
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int j = (m_ptr + k) % NREQ;
                if (req_valid[j]) begin
                    m_busy  = 1;
                    m_grant = j;
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (req_valid[m_grant]) begin
            m_wr_en = 1;
            m_addr  = req_addr[m_grant*ADDR +: ADDR];
            m_data  = req_data[m_grant*WIDTH +: WIDTH];
            m_cnt++;
            acc_cnt[m_grant]++;
            if (q[m_grant].size() > 0) void'(q[m_grant].pop_front());
            if (req_last[m_grant] || m_cnt == MAX_BURST) begin
                m_busy = 0;
                m_ptr  = (m_grant + 1) % NREQ;
            end
        end
    endtask

    task automatic check_outputs();
        chk("req_ready", 32'(req_ready), m_busy ? (32'd1 << m_grant) : 32'd0);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_grant));
        chk("wr_en", 32'(wr_en), 32'(m_wr_en));
        chk("wr_addr", 32'(wr_addr), 32'(m_addr));
        chk("wr_data", 32'(wr_data), 32'(m_data));
        if (busy && !prev_busy) grants.push_back(int'(grant_id));
        prev_busy = busy;
    endtask

    task automatic step();
        drive_inputs();
        #1;
        if (!rd_rst_n) model_reset();
        check_outputs();
        if (wr_en) mem_dut[wr_addr] = wr_data;
        @(posedge wrclk);
        model_step();
        @(negedge wrclk);
    endtask

    function automatic bit pending();
        bit p = m_busy;
        for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic run_until_idle(input string tag, input int budget);
        int c = 0;
        while (pending() && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_drained"}, 32'(c < budget), 32'd1);
        step();
    endtask

    task automatic run_until_acc(input string tag, input int i, input int n, input int budget);
        int c = 0;
        while (acc_cnt[i] < n && c < budget) begin
            step();
            c++;
        end
        chk({tag, "_accepted"}, 32'(c < budget), 32'd1);
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        chk({tag, "_count"}, 32'(grants.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < grants.size(); k++) begin
            chk($sformatf("%s_grant%0d", tag, k), 32'(grants[k]), 32'(exp[k]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order[$];
        int base;
        n_total = 0;
        n_pass  = 0;
        prev_busy = 0;
        for (int i = 0; i < NREQ; i++) begin
            stall[i]   = 0;
            acc_cnt[i] = 0;
        end
        for (int a = 0; a < DEPTH; a++) begin
            mem_model[a] = '0;
            mem_dut[a]   = '0;
        end
        model_reset();

        // Reset held with random requests
        junk_valid = 1;
        rd_rst_n   = 0;
        @(negedge wrclk);
        repeat (6) step();
        junk_valid = 0;
        rd_rst_n   = 1;
        step();

        // Single 3-beat burst from req0
        grants.delete();
        push(0, 2, 16'h00A1, 0);
        push(0, 3, 16'h00A2, 0);
        push(0, 4, 16'h00A3, 1);
        run_until_idle("t2", 30);
        chk("t2_mem2", 32'(mem_dut[2]), 32'h00A1);
        chk("t2_mem3", 32'(mem_dut[3]), 32'h00A2);
        chk("t2_mem4", 32'(mem_dut[4]), 32'h00A3);
        exp_order = '{0};
        check_order("t2", exp_order);

        // Round robin from a fresh pointer, single-beat bursts
        rd_rst_n = 0;
        step();
        rd_rst_n = 1;
        step();
        grants.delete();
        for (int i = 0; i < NREQ; i++) push(i, 8 + i, 16'h0B00 + i, 1);
        push(0, 12, 16'h0B10, 1);
        run_until_idle("t3", 40);
        exp_order = '{0, 1, 2, 3, 0};
        check_order("t3", exp_order);

        // Forced burst end, req2 served before req1 resumes; addresses wrap
        grants.delete();
        for (int k = 0; k < 10; k++) push(1, 10 + k, 16'h0C00 + k, k == 9);
        step();
        step();
        push(2, 1, 16'h0C20, 1);
        run_until_idle("t4", 60);
        exp_order = '{1, 2, 1};
        check_order("t4", exp_order);

        // Granted req3 stalls mid-burst while req0 waits
        grants.delete();
        for (int k = 0; k < 3; k++) push(3, 5 + k, 16'h0D30 + k, k == 2);
        push(0, 9, 16'h0D00, 1);
        base = acc_cnt[3];
        run_until_acc("t5", 3, base + 1, 20);
        stall[3] = 1;
        repeat (5) step();
        chk("t5_grant_held", 32'(grant_id), 32'd3);
        chk("t5_busy_held", 32'(busy), 32'd1);
        stall[3] = 0;
        run_until_idle("t5", 40);
        exp_order = '{3, 0};
        check_order("t5", exp_order);

        // Reset right after beat 2 of 4 is accepted
        grants.delete();
        for (int k = 0; k < 4; k++) push(2, 12 + k, 16'h0E20 + k, k == 3);
        base = acc_cnt[2];
        run_until_acc("t6", 2, base + 2, 20);
        rd_rst_n = 0;
        step();
        chk("t6_wr_en_dropped", 32'(wr_en), 32'd0);
        step();
        rd_rst_n = 1;
        grants.delete();
        push(0, 0, 16'h0E00, 1);
        push(1, 1, 16'h0E10, 1);
        run_until_idle("t6", 40);
        exp_order = '{0, 1, 2};
        check_order("t6", exp_order);

        // Randomized traffic with stalls
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (q[i].size() < 3 && $urandom_range(0, 3) == 0)
                    push(i, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 16'hFFFF)),
                         $urandom_range(0, 3) == 0);
                stall[i] = ($urandom_range(0, 4) == 0);
            end
            step();
        end
        for (int i = 0; i < NREQ; i++) begin
            stall[i] = 0;
            if (q[i].size() > 0) begin
                beat_t b = q[i].pop_back();
                b.last = 1;
                q[i].push_back(b);
            end
        end
        if (m_busy && q[m_grant].size() == 0) push(m_grant, 7, 16'h0F0F, 1);
        run_until_idle("rand", 300);

        for (int a = 0; a < DEPTH; a++)
            chk($sformatf("mem%0d", a), 32'(mem_dut[a]), 32'(mem_model[a]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
